// File: rtl/setassoc_cache.sv
// setassoc_cache: N-way set-associative write-through data cache with tree PLRU, hit/miss counters; optional write-allocate via CACHE_WRITE_ALLOCATE_EN
//
// Ports:
//   Clk, Rst_n                 clock (rising edge), asynchronous active-low reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata   CPU request, held until cpu_ready
//   cpu_rdata, cpu_ready       load data and one-cycle completion pulse
//   mem_rd_req/mem_wr_req      block fetch / word write-through, held until mem_ack
//   mem_addr, mem_wdata        memory address and write-through data
//   mem_rdata, mem_ack         fetched block (word 0 in [31:0]) and completion
//   hit_count, miss_count      saturating lookup counters
// Define CACHE_WRITE_ALLOCATE_EN to fetch and install the line on a store miss.
module setassoc_cache #(
  parameter int WAYS = 2,
  parameter int SETS = 64,
  parameter int BLOCK_WORDS = 4,
  parameter int ADDR_W = 32
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [ADDR_W-1:0]         cpu_addr,
  input  logic [31:0]               cpu_wdata,
  output logic [31:0]               cpu_rdata,
  output logic                      cpu_ready,
  output logic                      mem_rd_req,
  output logic                      mem_wr_req,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [31:0]               mem_wdata,
  input  logic [32*BLOCK_WORDS-1:0] mem_rdata,
  input  logic                      mem_ack,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count
);
  localparam int OB = $clog2(BLOCK_WORDS);
  localparam int IB = $clog2(SETS);
  localparam int LV = $clog2(WAYS);
  localparam int OW = OB > 0 ? OB : 1;
  localparam int IW = IB > 0 ? IB : 1;
  localparam int TAG_W = ADDR_W - 2 - OB - IB;
`ifdef CACHE_WRITE_ALLOCATE_EN
  localparam bit WA = 1'b1;
`else
  localparam bit WA = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WRITE, RESP} state_t;
  state_t state, state_d;

  logic [ADDR_W-1:0]         addr_q;
  logic                      we_q;
  logic [31:0]               wdata_q;
  logic                      hit_q;
  logic [LV-1:0]             way_q;
  logic [WAYS-1:0]           valid [SETS];
  logic [WAYS-2:0]           plru [SETS];
  logic [TAG_W-1:0]          tags [WAYS][SETS];
  logic [32*BLOCK_WORDS-1:0] lines [WAYS][SETS];

  logic [OW-1:0]             off;
  logic [IW-1:0]             idx;
  logic [TAG_W-1:0]          tag;
  logic                      hit;
  logic [LV-1:0]             hit_way;
  logic [LV-1:0]             victim;
  logic [32*BLOCK_WORDS-1:0] fill_line;

  assign off = OW'((addr_q >> 2) & ADDR_W'(BLOCK_WORDS - 1));
  assign idx = IW'((addr_q >> (2 + OB)) & ADDR_W'(SETS - 1));
  assign tag = TAG_W'(addr_q >> (2 + OB + IB));

  // Tree bits (heap order, node n has children 2n+1, 2n+2) point toward the LRU half.
  function automatic logic [LV-1:0] plru_way(input logic [WAYS-2:0] b);
    int n;
    n = 0;
    plru_way = '0;
    for (int l = 0; l < LV; l++) begin
      plru_way[LV-1-l] = b[n];
      n = 2 * n + 1 + int'(b[n]);
    end
  endfunction

  function automatic logic [WAYS-2:0] plru_upd(input logic [WAYS-2:0] b, input logic [LV-1:0] w);
    int n;
    n = 0;
    plru_upd = b;
    for (int l = 0; l < LV; l++) begin
      plru_upd[n] = ~w[LV-1-l];
      n = 2 * n + 1 + int'(w[LV-1-l]);
    end
  endfunction

  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid[idx][w] && tags[w][idx] == tag) begin
        hit = 1'b1;
        hit_way = LV'(w);
      end
    victim = plru_way(plru[idx]);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid[idx][w]) victim = LV'(w);
    fill_line = mem_rdata;
    if (we_q) fill_line[off*32 +: 32] = wdata_q;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = cpu_req ? LOOKUP : IDLE;
      LOOKUP:  state_d = hit ? (we_q ? WRITE : RESP) : ((we_q && !WA) ? WRITE : FILL);
      FILL:    state_d = mem_ack ? (we_q ? WRITE : RESP) : FILL;
      WRITE:   state_d = mem_ack ? RESP : WRITE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      state <= IDLE;
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      hit_q <= 1'b0;
      way_q <= '0;
      hit_count <= '0;
      miss_count <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        plru[s] <= '0;
      end
    end else begin
      state <= state_d;
      if (state == IDLE && cpu_req) begin
        addr_q <= cpu_addr;
        we_q <= cpu_we;
        wdata_q <= cpu_wdata;
      end
      if (state == LOOKUP) begin
        hit_q <= hit;
        way_q <= hit_way;
        if (hit) hit_count <= &hit_count ? hit_count : hit_count + 32'd1;
        else miss_count <= &miss_count ? miss_count : miss_count + 32'd1;
        if (hit && !we_q) plru[idx] <= plru_upd(plru[idx], hit_way);
      end
      // A filled store line is then treated as a hit by the following write-through.
      if (state == FILL && mem_ack) begin
        valid[idx][victim] <= 1'b1;
        plru[idx] <= plru_upd(plru[idx], victim);
        hit_q <= 1'b1;
        way_q <= victim;
      end
      if (state == WRITE && mem_ack && hit_q) plru[idx] <= plru_upd(plru[idx], way_q);
    end

  always_ff @(posedge Clk) begin
    if (state == FILL && mem_ack) begin
      lines[victim][idx] <= fill_line;
      tags[victim][idx] <= tag;
    end
    if (state == WRITE && mem_ack && hit_q) lines[way_q][idx][off*32 +: 32] <= wdata_q;
  end

  assign cpu_ready = state == RESP;
  assign cpu_rdata = (state == RESP && !we_q) ? lines[way_q][idx][off*32 +: 32] : '0;
  assign mem_rd_req = state == FILL;
  assign mem_wr_req = state == WRITE;
  assign mem_addr = (state == FILL) ? (addr_q & ~ADDR_W'(4 * BLOCK_WORDS - 1)) :
                    (state == WRITE) ? (addr_q & ~ADDR_W'(3)) : '0;
  assign mem_wdata = (state == WRITE) ? wdata_q : '0;
endmodule

// File: tb/tb_setassoc_cache.sv
// tb_setassoc_cache: directed self-checking bench for setassoc_cache (WAYS=2, SETS=64, BLOCK_WORDS=4)
module tb_setassoc_cache;
  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic         cpu_req = 1'b0;
  logic         cpu_we = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [31:0]  cpu_rdata;
  logic         cpu_ready;
  logic         mem_rd_req;
  logic         mem_wr_req;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  int checks = 0;
  int errors = 0;
  int n_rd, n_wr, lat;
  logic [31:0] rdata, rd_addr, wr_addr, wr_data;

  setassoc_cache #(.WAYS(2), .SETS(64), .BLOCK_WORDS(4), .ADDR_W(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Runs one CPU transaction, acking each memory request one cycle after it is seen.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [127:0] blk);
    int cyc;
    bit done;
    @(negedge Clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    n_rd = 0; n_wr = 0; lat = 0; rdata = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge Clk);
      cyc++;
      mem_ack = 1'b0;
      if (cpu_ready) begin
        rdata = cpu_rdata; lat = cyc; done = 1'b1;
      end else if (mem_rd_req) begin
        n_rd++; rd_addr = mem_addr; mem_rdata = blk; mem_ack = 1'b1;
      end else if (mem_wr_req) begin
        n_wr++; wr_addr = mem_addr; wr_data = mem_wdata; mem_ack = 1'b1;
      end
    end
    cpu_req = 1'b0;
    mem_ack = 1'b0;
    if (!done) check("timeout", 32'(cyc), 32'd0);
  endtask

  initial begin
    int bad;
    repeat (2) @(negedge Clk);
    check("rst_ready", cpu_ready, 0);
    check("rst_rdreq", mem_rd_req, 0);
    check("rst_wrreq", mem_wr_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_hits", hit_count, 0);
    check("rst_miss", miss_count, 0);
    Rst_n = 1'b1;

    access(0, 32'h40, 0, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
    check("cold_nrd", n_rd, 1);
    check("cold_rdaddr", rd_addr, 32'h40);
    check("cold_rdata", rdata, 32'hD0);
    check("cold_lat", lat, 3);
    check("cold_miss", miss_count, 1);

    access(0, 32'h44, 0, '0);
    check("hit_rdata", rdata, 32'hD1);
    check("hit_nrd", n_rd, 0);
    check("hit_lat", lat, 2);
    check("hit_hits", hit_count, 1);

    access(0, 32'h000, 0, {32'h103, 32'h102, 32'h101, 32'h100});
    check("rep_a_nrd", n_rd, 1);
    access(0, 32'h400, 0, {32'h203, 32'h202, 32'h201, 32'h200});
    check("rep_b_nrd", n_rd, 1);
    check("rep_b_rdata", rdata, 32'h200);
    access(0, 32'h000, 0, '0);
    check("rep_a_hit", n_rd, 0);
    check("rep_a_rdata", rdata, 32'h100);
    access(0, 32'h808, 0, {32'h303, 32'h302, 32'h301, 32'h300});
    check("rep_c_rdaddr", rd_addr, 32'h800);
    check("rep_c_rdata", rdata, 32'h302);
    access(0, 32'h00C, 0, '0);
    check("rep_a_kept", n_rd, 0);
    check("rep_a_rdata2", rdata, 32'h103);
    access(0, 32'h400, 0, {32'h203, 32'h202, 32'h201, 32'h200});
    check("rep_b_evicted", n_rd, 1);
    check("rep_miss", miss_count, 5);
    check("rep_hits", hit_count, 3);

    access(1, 32'h44, 32'hDEADBEEF, '0);
    check("wh_nwr", n_wr, 1);
    check("wh_nrd", n_rd, 0);
    check("wh_addr", wr_addr, 32'h44);
    check("wh_data", wr_data, 32'hDEADBEEF);
    check("wh_lat", lat, 3);
    access(0, 32'h44, 0, '0);
    check("wh_rdata", rdata, 32'hDEADBEEF);
    check("wh_rd_nrd", n_rd, 0);
    check("wh_hits", hit_count, 5);

    access(1, 32'h1000, 32'h12345678, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    check("wm_nwr", n_wr, 1);
    check("wm_wraddr", wr_addr, 32'h1000);
    check("wm_wrdata", wr_data, 32'h12345678);
    check("wm_miss", miss_count, 6);
`ifdef CACHE_WRITE_ALLOCATE_EN
    check("wm_nrd", n_rd, 1);
    check("wm_rdaddr", rd_addr, 32'h1000);
    check("wm_lat", lat, 4);
    access(0, 32'h1000, 0, '0);
    check("wm_rd_nrd", n_rd, 0);
    check("wm_rdata", rdata, 32'h12345678);
    access(0, 32'h1004, 0, '0);
    check("wm_rdata1", rdata, 32'hA1);
    check("wm_hits", hit_count, 7);
`else
    check("wm_nrd", n_rd, 0);
    check("wm_lat", lat, 3);
    access(0, 32'h1000, 0, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    check("wm_rd_nrd", n_rd, 1);
    check("wm_rdata", rdata, 32'hA0);
    check("wm_miss2", miss_count, 7);
    check("wm_hits", hit_count, 5);
`endif

    @(negedge Clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h84;
    bad = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge Clk);
      if (c == 1) cpu_req = 1'b0;
      if (cpu_ready) bad++;
      if (c >= 2 && (mem_rd_req !== 1'b1 || mem_addr !== 32'h80 || mem_wr_req !== 1'b0)) bad++;
    end
    check("stall_stable", 32'(bad), 0);
    check("stall_rdreq", mem_rd_req, 1);
    Rst_n = 1'b0;
    #1;
    check("ar_ready", cpu_ready, 0);
    check("ar_rdata", cpu_rdata, 0);
    check("ar_rdreq", mem_rd_req, 0);
    check("ar_wrreq", mem_wr_req, 0);
    check("ar_addr", mem_addr, 0);
    check("ar_wdata", mem_wdata, 0);
    check("ar_hits", hit_count, 0);
    check("ar_miss", miss_count, 0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;

    access(0, 32'h40, 0, {32'hE3, 32'hE2, 32'hE1, 32'hE0});
    check("post_nrd", n_rd, 1);
    check("post_rdata", rdata, 32'hE0);
    check("post_miss", miss_count, 1);
    check("post_hits", hit_count, 0);
    access(0, 32'h84, 0, {32'hF3, 32'hF2, 32'hF1, 32'hF0});
    check("post_abandon", n_rd, 1);
    check("post_abandon_rdata", rdata, 32'hF1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/setassoc_cache.md
# setassoc_cache

Parametrised N-way set-associative, write-through data cache between the pipeline's memory stage and main memory. It generalises the team's fixed 2-way cache in several ways:

- Configurable ways, sets and block size.
- Fully clocked FSM with a request/ready handshake on both sides.
- Invalid-first victim selection with tree pseudo-LRU.
- Hit/miss performance counters.
- Optional write-allocate.

## Interface
Parameters:
- WAYS, 2, associativity; power of two, 2..8
- SETS, 64, sets; power of two
- BLOCK_WORDS, 4, 32-bit words per line; power of two
- ADDR_W, 32, byte-address width

Ports:
- Clk  in  1  clock, all state updates on rising edge
- Rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  request valid; held with stable cpu_addr/cpu_we/cpu_wdata until cpu_ready
- cpu_we  in  1  1 = store word, 0 = load word
- cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data, valid while cpu_ready
- cpu_ready  out  1  one-cycle completion pulse
- mem_rd_req  out  1  block fetch request, held until mem_ack
- mem_wr_req  out  1  word write-through request, held until mem_ack
- mem_addr  out  ADDR_W  block-aligned for reads, word-aligned for writes
- mem_wdata  out  32  write-through data
- mem_rdata  in  32*BLOCK_WORDS  fetched block; word 0 in bits [31:0]; sampled on the mem_ack cycle
- mem_ack  in  1  one-cycle memory completion
- hit_count  out  32  saturating lookup-hit counter
- miss_count  out  32  saturating lookup-miss counter

## Operation

Address split:
- offset = addr[log2(BLOCK_WORDS)+1:2]
- index = next log2(SETS) bits
- tag = remaining upper bits

Per-line storage is valid + tag + data. Each set also holds WAYS-1 PLRU bits.

FSM states:
- IDLE: when cpu_req=1, register addr/we/wdata → LOOKUP.
- LOOKUP: compare the registered tag against all ways. Exactly one way can match by construction.
  - Hit: hit_count++.
  - Miss: miss_count++.
  - Read hit → RESP; PLRU points away from the hit way.
  - Read miss → FILL.
  - Write hit → WRITE.
  - Write miss → WRITE, or FILL when write-allocate is enabled.
- FILL: mem_rd_req=1, mem_addr = block address.
  - On mem_ack, install mem_rdata into the victim way. A store merges cpu_wdata at the offset before install.
  - Victim = lowest-index invalid way if any, else the PLRU way.
  - Set valid, write tag, update PLRU.
  - → RESP for a read, → WRITE for a store.
- WRITE: mem_wr_req=1, mem_addr = word address, mem_wdata = stored word.
  - On mem_ack, a hit updates that word in the hit way and updates PLRU.
  - → RESP.
- RESP: cpu_ready=1 for one cycle. For a read, cpu_rdata = word at offset from the hit/filled line. → IDLE.

Other rules:
- mem_ack outside FILL/WRITE is ignored.
- mem_rd_req and mem_wr_req are never both high.
- Counters saturate at 0xFFFF_FFFF.

## Timing

Reset (Rst_n low, asynchronous):
- State → IDLE.
- All valid bits, PLRU bits and counters → 0.
- cpu_rdata, cpu_ready, mem_rd_req, mem_wr_req, mem_addr, mem_wdata → 0.
- Reset mid-FILL/WRITE abandons the transaction; no line is installed.

Latencies:
- Read hit: cpu_req sampled at edge E → cpu_ready high in the cycle after E+1 (two-cycle latency).
- Miss: mem_rd_req rises the cycle after LOOKUP. cpu_ready follows mem_ack by one cycle (read), or by write-through plus one (store).
- Write hit: mem_wr_req the cycle after LOOKUP. cpu_ready the cycle after mem_ack.

Handshake rules:
- Earliest next request is sampled the cycle after cpu_ready.
- mem_addr and mem_wdata are stable for the full duration of a request.

## Configuration
- CACHE_WRITE_ALLOCATE_EN defined: a write miss runs FILL, merges the store word into the fetched line, installs it, then writes through.
- CACHE_WRITE_ALLOCATE_EN undefined: a write miss only writes through. Cache contents and PLRU are unchanged.

## Test plan

All scenarios use WAYS=2, SETS=64, BLOCK_WORDS=4 (set stride 0x400).

- Cold read miss then hit:
  - Stimulus: after reset, read 0x40.
  - Expect mem_rd_req with mem_addr=0x40. Ack with words {0xD3,0xD2,0xD1,0xD0} → cpu_rdata=0xD0, miss_count=1.
  - Then read 0x44 → cpu_rdata=0xD1 two cycles after sampling, no memory request, hit_count=1.
- Replacement:
  - Stimulus: read 0x000, read 0x400, read 0x000 (hit), then read 0x800.
  - Expect 0x800 to replace the 0x400 line: read 0x000 hits, read 0x400 misses.
- Write hit:
  - Stimulus: write 0xDEADBEEF to 0x44.
  - Expect mem_wr_req with mem_addr=0x44, mem_wdata=0xDEADBEEF. After ack, read 0x44 returns 0xDEADBEEF with no mem_rd_req.
- Write miss to 0x1000, data 0x12345678:
  - With macro: mem_rd_req(0x1000), then mem_wr_req(0x1000); a later read of 0x1000 hits and returns 0x12345678.
  - Without macro: only mem_wr_req; a later read of 0x1000 misses.
- Stall and reset:
  - Stimulus: hold mem_ack low for 20 cycles on a read miss.
  - Expect mem_rd_req and mem_addr stable, cpu_ready=0.
  - Drive Rst_n low at cycle 10: all outputs and counters read 0 immediately, and a re-read of 0x40 misses.
